// File: rtl/lockout_timer.sv
// Lockout responder: on a sleep rising edge, counts down min(SLEEP_SECONDS<<strikes, MAX_SECONDS) s, then pulses end_sleep.
// Latency: end_sleep in cycle D*CLK_HZ+1 after the start edge; no backpressure, a new lockout needs a fresh sleep edge.
module lockout_timer #(
  parameter int CLK_HZ        = 50000000,
  parameter int SLEEP_SECONDS = 5,
  parameter int MAX_SECONDS   = 60
) (
  input  logic       clk,
  input  logic       system_reset,
  input  logic       sleep,
  input  logic       clear_strikes,
  output logic       end_sleep,
  output logic       sleeping,
  output logic [7:0] seconds_left,
  output logic [1:0] strikes,
  output logic [7:0] hex_seg
);

  localparam int PW = $clog2(CLK_HZ);
  localparam logic [PW-1:0] PS_LAST = PW'(CLK_HZ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_sleep_d;
  logic [PW-1:0]   r_presc;
  logic [PW-1:0]   w_presc_nxt;
  logic [7:0]      r_secs;
  logic [7:0]      w_secs_nxt;
  logic [1:0]      r_strikes;
  logic [1:0]      w_strikes_nxt;
  logic            w_start;
  logic            w_tick;
  logic [11:0]     w_scaled;
  logic [7:0]      w_dur;
  logic [3:0]      w_ones;

  assign w_start  = sleep & ~r_sleep_d;
  assign w_tick   = (r_presc == PS_LAST);

  // Shift at 12 bits so 255<<3 cannot wrap before the cap is applied.
  assign w_scaled = 12'(SLEEP_SECONDS) << r_strikes;
  assign w_dur    = (w_scaled > 12'(MAX_SECONDS)) ? 8'(MAX_SECONDS) : w_scaled[7:0];

  always_ff @(posedge clk) begin
    if (system_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_presc_nxt   = r_presc;
    w_secs_nxt    = r_secs;
    w_strikes_nxt = r_strikes;
    sleeping      = 1'b0;
    end_sleep     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_state_nxt = COUNT;
          w_secs_nxt  = w_dur;
          w_presc_nxt = '0;
        end
      end
      COUNT: begin
        sleeping = 1'b1;
        // Abort outranks the final tick.
        if (!sleep) begin
          w_state_nxt = IDLE;
          w_secs_nxt  = 8'd0;
          w_presc_nxt = '0;
        end else if (w_tick) begin
          w_presc_nxt = '0;
          w_secs_nxt  = r_secs - 8'd1;
          if (r_secs == 8'd1) begin
            w_state_nxt = DONE;
          end
        end else begin
          w_presc_nxt = r_presc + 1'b1;
        end
      end
      DONE: begin
        end_sleep = 1'b1;
        if (r_strikes != 2'd3) begin
          w_strikes_nxt = r_strikes + 2'd1;
        end
        w_state_nxt = sleep ? HOLD : IDLE;
      end
      HOLD: begin
        if (!sleep) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (clear_strikes) begin
      w_strikes_nxt = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (system_reset) begin
      r_sleep_d <= 1'b0;
      r_presc   <= '0;
      r_secs    <= 8'd0;
      r_strikes <= 2'd0;
    end else begin
      r_sleep_d <= sleep;
      r_presc   <= w_presc_nxt;
      r_secs    <= w_secs_nxt;
      r_strikes <= w_strikes_nxt;
    end
  end

  assign w_ones = 4'(r_secs % 8'd10);

  always_comb begin
    hex_seg = 8'hFF;
    if (sleeping) begin
      case (w_ones)
        4'd0:    hex_seg = 8'hC0;
        4'd1:    hex_seg = 8'hF9;
        4'd2:    hex_seg = 8'hA4;
        4'd3:    hex_seg = 8'hB0;
        4'd4:    hex_seg = 8'h99;
        4'd5:    hex_seg = 8'h92;
        4'd6:    hex_seg = 8'h82;
        4'd7:    hex_seg = 8'hF8;
        4'd8:    hex_seg = 8'h80;
        4'd9:    hex_seg = 8'h90;
        default: hex_seg = 8'hFF;
      endcase
    end
  end

  assign seconds_left = r_secs;
  assign strikes      = r_strikes;

endmodule

// File: tb/tb_lockout_timer.sv
// Bench for lockout_timer: directed scenarios plus random lockouts, predicted from arithmetic on durations and cycle offsets.
module tb_lockout_timer;

  localparam int HZ  = 4;
  localparam int SS  = 3;
  localparam int MAX = 10;

  logic       clk;
  logic       system_reset;
  logic       sleep;
  logic       clear_strikes;
  logic       end_sleep;
  logic       sleeping;
  logic [7:0] seconds_left;
  logic [1:0] strikes;
  logic [7:0] hex_seg;

  int n_tests = 0;
  int n_fail  = 0;
  int m_strikes = 0;

  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  lockout_timer #(.CLK_HZ(HZ), .SLEEP_SECONDS(SS), .MAX_SECONDS(MAX)) dut (
    .clk           (clk),
    .system_reset  (system_reset),
    .sleep         (sleep),
    .clear_strikes (clear_strikes),
    .end_sleep     (end_sleep),
    .sleeping      (sleeping),
    .seconds_left  (seconds_left),
    .strikes       (strikes),
    .hex_seg       (hex_seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dur_of(input int s);
    int d;
    d = SS * (1 << s);
    return (d > MAX) ? MAX : d;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic e_sl, input logic e_end, input int e_secs);
    logic [7:0] e_hex;
    e_hex = e_sl ? seg_tab[e_secs % 10] : 8'hFF;
    chk({tag, "_sleeping"}, 32'(sleeping), 32'(e_sl));
    chk({tag, "_end_sleep"}, 32'(end_sleep), 32'(e_end));
    chk({tag, "_seconds"}, 32'(seconds_left), 32'(e_secs));
    chk({tag, "_strikes"}, 32'(strikes), 32'(m_strikes));
    chk({tag, "_hex"}, 32'(hex_seg), 32'(e_hex));
  endtask

  // Idle cycles with sleep low; optionally random clear_strikes pulses.
  task automatic idle(input int n, input bit rnd_clr);
    for (int i = 0; i < n; i++) begin
      clear_strikes = rnd_clr ? 1'($urandom_range(0, 1)) : 1'b0;
      if (clear_strikes) m_strikes = 0;
      @(negedge clk);
      clear_strikes = 1'b0;
      chk_out("idle", 1'b0, 1'b0, 0);
    end
  endtask

  // One lockout from IDLE. abort_at: cycle in which sleep drops (0 = never).
  // clr_at: cycle in which clear_strikes is pulsed (-1 = never). hold_len: cycles sleep stays high after DONE.
  task automatic lockout(input int abort_at, input int clr_at, input int hold_len);
    int d;
    int t;
    d = dur_of(m_strikes);
    t = d * HZ;
    sleep = 1'b1;
    for (int k = 1; k <= t; k++) begin
      @(negedge clk);
      clear_strikes = 1'b0;
      chk_out("count", 1'b1, 1'b0, d - (k - 1) / HZ);
      if (k == clr_at) begin
        clear_strikes = 1'b1;
        m_strikes = 0;
      end
      if (k == abort_at) begin
        sleep = 1'b0;
        @(negedge clk);
        clear_strikes = 1'b0;
        chk_out("abort", 1'b0, 1'b0, 0);
        return;
      end
    end
    @(negedge clk);
    clear_strikes = 1'b0;
    chk_out("done", 1'b0, 1'b1, 0);
    if (clr_at == t + 1) begin
      clear_strikes = 1'b1;
      m_strikes = 0;
    end else begin
      m_strikes = (m_strikes < 3) ? m_strikes + 1 : 3;
    end
    if (hold_len == 0) sleep = 1'b0;
    for (int k = 0; k < hold_len; k++) begin
      @(negedge clk);
      clear_strikes = 1'b0;
      chk_out("hold", 1'b0, 1'b0, 0);
    end
    sleep = 1'b0;
    @(negedge clk);
    clear_strikes = 1'b0;
    chk_out("release", 1'b0, 1'b0, 0);
  endtask

  initial begin
    int t;
    int ab;
    int cl;
    system_reset  = 1'b1;
    sleep         = 1'b0;
    clear_strikes = 1'b0;
    repeat (3) @(negedge clk);
    chk_out("reset", 1'b0, 1'b0, 0);
    system_reset = 1'b0;
    idle(2, 1'b0);

    // Basic lockout (3 s), then sleep held 40 cycles with no retrigger.
    lockout(0, -1, 40);
    chk("basic_strikes", 32'(strikes), 32'd1);
    // Escalation: 6 s, then 10 s (capped from 12), then 10 s with strikes saturated.
    lockout(0, -1, 0);
    chk("esc2_strikes", 32'(strikes), 32'd2);
    lockout(0, -1, 3);
    chk("esc3_strikes", 32'(strikes), 32'd3);
    lockout(0, -1, 0);
    chk("esc4_strikes", 32'(strikes), 32'd3);
    idle(2, 1'b0);

    // Abort at cycle 6; strikes unchanged.
    lockout(6, -1, 0);
    idle(4, 1'b0);
    chk("abort_strikes", 32'(strikes), 32'd3);

    // Clear mid-count, then clear colliding with DONE.
    lockout(0, 1, 0);
    chk("clr_mid_strikes", 32'(strikes), 32'd1);
    t = dur_of(m_strikes) * HZ;
    lockout(0, t + 1, 0);
    idle(1, 1'b0);
    chk("clr_done_strikes", 32'(strikes), 32'd0);

    // Abort on the cycle of the final tick: abort must win.
    t = dur_of(m_strikes) * HZ;
    lockout(t, -1, 0);
    idle(3, 1'b0);

    // Reset in cycle 7 of a countdown.
    sleep = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk_out("rst_count", 1'b1, 1'b0, dur_of(m_strikes) - (k - 1) / HZ);
    end
    system_reset = 1'b1;
    @(negedge clk);
    m_strikes = 0;
    chk_out("rst_mid", 1'b0, 1'b0, 0);
    system_reset = 1'b0;
    sleep = 1'b0;
    idle(6, 1'b0);

    // Random lockouts with random aborts, clears and hold lengths.
    for (int it = 0; it < 25; it++) begin
      idle(int'($urandom_range(1, 3)), 1'b1);
      t  = dur_of(m_strikes) * HZ;
      ab = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, t));
      cl = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, t + 1)) : -1;
      lockout(ab, cl, int'($urandom_range(0, 5)));
    end
    idle(2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
